// File: rtl/mor1kx_bus_arbiter_wb32.sv
// Two-master Wishbone arbiter: ibus and dbus share one classic/burst Wishbone master port.
// Grants are held for a whole cycle/burst; a stalled slave is released by a response timeout.
module mor1kx_bus_arbiter_wb32 #(
    parameter string ARB_SCHEME = "ROUND_ROBIN",
    parameter int    TIMEOUT    = 255,
    parameter int    TIMEOUT_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ibus_cyc_i,
    input  logic        ibus_stb_i,
    input  logic        ibus_we_i,
    input  logic [3:0]  ibus_sel_i,
    input  logic [31:0] ibus_adr_i,
    input  logic [31:0] ibus_dat_i,
    input  logic [2:0]  ibus_cti_i,
    input  logic [1:0]  ibus_bte_i,
    output logic        ibus_ack_o,
    output logic        ibus_err_o,
    output logic        ibus_rty_o,
    output logic [31:0] ibus_dat_o,

    input  logic        dbus_cyc_i,
    input  logic        dbus_stb_i,
    input  logic        dbus_we_i,
    input  logic [3:0]  dbus_sel_i,
    input  logic [31:0] dbus_adr_i,
    input  logic [31:0] dbus_dat_i,
    input  logic [2:0]  dbus_cti_i,
    input  logic [1:0]  dbus_bte_i,
    output logic        dbus_ack_o,
    output logic        dbus_err_o,
    output logic        dbus_rty_o,
    output logic [31:0] dbus_dat_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    input  logic [31:0] wbm_dat_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;

    localparam bit                   DBUS_PRIO = (ARB_SCHEME == "DBUS_PRIORITY");
    localparam bit                   TO_EN     = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TO_VAL    = TIMEOUT_W'(TIMEOUT);

    state_t               state_q, state_d;
    logic                 last_gnt_q, last_gnt_d;   // 1 = dbus was granted last
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 resp;
    logic                 to_hit;
    logic                 gnt_entry;

    assign resp       = wbm_ack_i | wbm_err_i | wbm_rty_i;
    assign to_hit     = TO_EN && (cnt_q == TO_VAL) && !resp;
    assign ibus_dat_o = wbm_dat_i;
    assign dbus_dat_o = wbm_dat_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                // Ties go to dbus unless round-robin says ibus is owed a turn.
                if (ibus_cyc_i && dbus_cyc_i)
                    state_d = (DBUS_PRIO || !last_gnt_q) ? GNT_D : GNT_I;
                else if (dbus_cyc_i)
                    state_d = GNT_D;
                else if (ibus_cyc_i)
                    state_d = GNT_I;
            end
            GNT_I: begin
                if (!ibus_cyc_i)
                    state_d = dbus_cyc_i ? GNT_D : IDLE;
                else if (to_hit)
                    state_d = ABORT;
            end
            GNT_D: begin
                if (!dbus_cyc_i)
                    state_d = ibus_cyc_i ? GNT_I : IDLE;
                else if (to_hit)
                    state_d = ABORT;
            end
            default: state_d = IDLE;
        endcase
        gnt_entry = (state_d == GNT_I || state_d == GNT_D) && (state_d != state_q);
        if (gnt_entry)
            last_gnt_d = (state_d == GNT_D);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (gnt_entry || resp)
            cnt_d = '0;
        else if ((state_q == GNT_I || state_q == GNT_D) && wbm_stb_o && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_sel_o  = '0;
        wbm_adr_o  = '0;
        wbm_dat_o  = '0;
        wbm_cti_o  = '0;
        wbm_bte_o  = '0;
        ibus_ack_o = 1'b0;
        ibus_err_o = 1'b0;
        ibus_rty_o = 1'b0;
        dbus_ack_o = 1'b0;
        dbus_err_o = 1'b0;
        dbus_rty_o = 1'b0;
        grant_o    = 2'b00;
        case (state_q)
            GNT_I: begin
                wbm_cyc_o  = ibus_cyc_i;
                wbm_stb_o  = ibus_stb_i;
                wbm_we_o   = ibus_we_i;
                wbm_sel_o  = ibus_sel_i;
                wbm_adr_o  = ibus_adr_i;
                wbm_dat_o  = ibus_dat_i;
                wbm_cti_o  = ibus_cti_i;
                wbm_bte_o  = ibus_bte_i;
                ibus_ack_o = wbm_ack_i;
                ibus_err_o = wbm_err_i;
                ibus_rty_o = wbm_rty_i;
                grant_o    = 2'b01;
            end
            GNT_D: begin
                wbm_cyc_o  = dbus_cyc_i;
                wbm_stb_o  = dbus_stb_i;
                wbm_we_o   = dbus_we_i;
                wbm_sel_o  = dbus_sel_i;
                wbm_adr_o  = dbus_adr_i;
                wbm_dat_o  = dbus_dat_i;
                wbm_cti_o  = dbus_cti_i;
                wbm_bte_o  = dbus_bte_i;
                dbus_ack_o = wbm_ack_i;
                dbus_err_o = wbm_err_i;
                dbus_rty_o = wbm_rty_i;
                grant_o    = 2'b10;
            end
            ABORT: begin
                // The aborted owner is always the last port granted.
                dbus_err_o = last_gnt_q;
                ibus_err_o = !last_gnt_q;
                grant_o    = last_gnt_q ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mor1kx_bus_arbiter_wb32.sv
// Directed bench for mor1kx_bus_arbiter_wb32: a per-cycle vector table plus hand-written
// sequences for back-to-back round-robin, bursts, timeout abort and asynchronous reset.
module tb_mor1kx_bus_arbiter_wb32;

    localparam logic [31:0] A1 = 32'h1000_0000;
    localparam logic [31:0] D1 = 32'h2000_0040;
    localparam logic [31:0] IDAT = 32'h1111_2222;
    localparam logic [31:0] DDAT = 32'hCAFE_0003;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        icyc, istb, iwe, dcyc, dstb, dwe;
    logic [3:0]  isel, dsel;
    logic [31:0] iadr, idat, dadr, ddat;
    logic [2:0]  icti, dcti;
    logic [1:0]  ibte, dbte;
    logic        ack, err, rty;
    logic [31:0] rdat;

    logic        iack, ierr, irty, dack, derr, drty;
    logic [31:0] idat_o, ddat_o;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic [2:0]  cti;
    logic [1:0]  bte, grant;

    logic        p_iack, p_ierr, p_irty, p_dack, p_derr, p_drty;
    logic [31:0] p_idat, p_ddat;
    logic        p_cyc, p_stb, p_we;
    logic [3:0]  p_sel;
    logic [31:0] p_adr, p_dat;
    logic [2:0]  p_cti;
    logic [1:0]  p_bte, p_grant;

    logic [5:0] rsp, p_rsp;
    assign rsp   = {iack, ierr, irty, dack, derr, drty};
    assign p_rsp = {p_iack, p_ierr, p_irty, p_dack, p_derr, p_drty};

    mor1kx_bus_arbiter_wb32 #(.ARB_SCHEME("ROUND_ROBIN"), .TIMEOUT(4), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_cyc_i(icyc), .ibus_stb_i(istb), .ibus_we_i(iwe), .ibus_sel_i(isel),
        .ibus_adr_i(iadr), .ibus_dat_i(idat), .ibus_cti_i(icti), .ibus_bte_i(ibte),
        .ibus_ack_o(iack), .ibus_err_o(ierr), .ibus_rty_o(irty), .ibus_dat_o(idat_o),
        .dbus_cyc_i(dcyc), .dbus_stb_i(dstb), .dbus_we_i(dwe), .dbus_sel_i(dsel),
        .dbus_adr_i(dadr), .dbus_dat_i(ddat), .dbus_cti_i(dcti), .dbus_bte_i(dbte),
        .dbus_ack_o(dack), .dbus_err_o(derr), .dbus_rty_o(drty), .dbus_dat_o(ddat_o),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_cti_o(cti), .wbm_bte_o(bte),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty), .wbm_dat_i(rdat),
        .grant_o(grant)
    );

    mor1kx_bus_arbiter_wb32 #(.ARB_SCHEME("DBUS_PRIORITY"), .TIMEOUT(0), .TIMEOUT_W(8)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .ibus_cyc_i(icyc), .ibus_stb_i(istb), .ibus_we_i(iwe), .ibus_sel_i(isel),
        .ibus_adr_i(iadr), .ibus_dat_i(idat), .ibus_cti_i(icti), .ibus_bte_i(ibte),
        .ibus_ack_o(p_iack), .ibus_err_o(p_ierr), .ibus_rty_o(p_irty), .ibus_dat_o(p_idat),
        .dbus_cyc_i(dcyc), .dbus_stb_i(dstb), .dbus_we_i(dwe), .dbus_sel_i(dsel),
        .dbus_adr_i(dadr), .dbus_dat_i(ddat), .dbus_cti_i(dcti), .dbus_bte_i(dbte),
        .dbus_ack_o(p_dack), .dbus_err_o(p_derr), .dbus_rty_o(p_drty), .dbus_dat_o(p_ddat),
        .wbm_cyc_o(p_cyc), .wbm_stb_o(p_stb), .wbm_we_o(p_we), .wbm_sel_o(p_sel),
        .wbm_adr_o(p_adr), .wbm_dat_o(p_dat), .wbm_cti_o(p_cti), .wbm_bte_o(p_bte),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty), .wbm_dat_i(rdat),
        .grant_o(p_grant)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        icyc;
        logic        dcyc;
        logic        ack;
        logic        err;
        logic        rty;
        logic [1:0]  e_gnt;
        logic        e_cyc;
        logic [31:0] e_adr;
        logic [5:0]  e_rsp;   // {iack,ierr,irty,dack,derr,drty}
    } vec_t;

    function automatic vec_t mk(input logic ic, input logic dc, input logic a, input logic e,
                                input logic r, input logic [1:0] g, input logic c,
                                input logic [31:0] ad, input logic [5:0] rs);
        vec_t v;
        v.icyc = ic; v.dcyc = dc; v.ack = a; v.err = e; v.rty = r;
        v.e_gnt = g; v.e_cyc = c; v.e_adr = ad; v.e_rsp = rs;
        return v;
    endfunction

    task automatic set_req(input logic ic, input logic dc);
        icyc = ic; istb = ic;
        dcyc = dc; dstb = dc;
    endtask

    task automatic clear_inputs();
        set_req(1'b0, 1'b0);
        iwe = 1'b0; isel = 4'hf; iadr = A1; idat = IDAT; icti = 3'b000; ibte = 2'b00;
        dwe = 1'b1; dsel = 4'hc; dadr = D1; ddat = DDAT; dcti = 3'b000; dbte = 2'b00;
        ack = 1'b0; err = 1'b0; rty = 1'b0; rdat = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 6'b000000);
        tbl[1]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 32'h0, 6'b000000);
        tbl[2]  = mk(1, 0, 0, 0, 0, 2'b01, 1, A1,    6'b000000);
        tbl[3]  = mk(1, 0, 1, 0, 0, 2'b01, 1, A1,    6'b100000);
        tbl[4]  = mk(0, 0, 0, 0, 0, 2'b01, 0, A1,    6'b000000);
        tbl[5]  = mk(0, 1, 1, 0, 0, 2'b00, 0, 32'h0, 6'b000000);
        tbl[6]  = mk(1, 1, 0, 0, 0, 2'b10, 1, D1,    6'b000000);
        tbl[7]  = mk(1, 1, 1, 0, 0, 2'b10, 1, D1,    6'b000100);
        tbl[8]  = mk(1, 0, 0, 0, 0, 2'b10, 0, D1,    6'b000000);
        tbl[9]  = mk(1, 0, 0, 1, 0, 2'b01, 1, A1,    6'b010000);
        tbl[10] = mk(1, 0, 0, 0, 1, 2'b01, 1, A1,    6'b001000);
        tbl[11] = mk(0, 0, 0, 0, 0, 2'b01, 0, A1,    6'b000000);
        tbl[12] = mk(1, 1, 0, 0, 0, 2'b00, 0, 32'h0, 6'b000000);
        tbl[13] = mk(1, 1, 0, 0, 0, 2'b10, 1, D1,    6'b000000);
        tbl[14] = mk(1, 0, 0, 0, 0, 2'b10, 0, D1,    6'b000000);
        tbl[15] = mk(1, 0, 1, 0, 0, 2'b01, 1, A1,    6'b100000);
        tbl[16] = mk(0, 0, 0, 0, 0, 2'b01, 0, A1,    6'b000000);
        tbl[17] = mk(0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 6'b000000);

        // Reset holds everything quiet even with requests and responses active.
        clear_inputs();
        set_req(1'b1, 1'b1);
        ack = 1'b1; err = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_cycstb", 32'({cyc, stb}), 32'h0);
        chk("rst_adr", adr, 32'h0);
        chk("rst_rsp", 32'(rsp), 32'h0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_req(tbl[i].icyc, tbl[i].dcyc);
            ack = tbl[i].ack; err = tbl[i].err; rty = tbl[i].rty;
            rdat = 32'hA5A5_0000 | 32'(i);
            #1;
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tbl[i].e_gnt));
            chk($sformatf("v%0d_cycstb", i), 32'({cyc, stb}), 32'({tbl[i].e_cyc, tbl[i].e_cyc}));
            chk($sformatf("v%0d_adr", i), adr, tbl[i].e_adr);
            chk($sformatf("v%0d_rsp", i), 32'(rsp), 32'(tbl[i].e_rsp));
            chk($sformatf("v%0d_idat", i), idat_o, 32'hA5A5_0000 | 32'(i));
            chk($sformatf("v%0d_ddat", i), ddat_o, 32'hA5A5_0000 | 32'(i));
            @(negedge clk);
        end

        // Round-robin back-to-back: D,I,D,I,D,I with one cyc-low handover cycle, never IDLE.
        do_reset();
        set_req(1'b1, 1'b1);
        #1 chk("rr_idle", 32'(grant), 32'h0);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            logic own_d;
            own_d = (k % 2 == 0);
            set_req(1'b1, 1'b1);
            ack = 1'b1;
            #1;
            chk($sformatf("rr%0d_grant", k), 32'(grant), own_d ? 32'h2 : 32'h1);
            chk($sformatf("rr%0d_cyc", k), 32'(cyc), 32'h1);
            chk($sformatf("rr%0d_rsp", k), 32'(rsp), own_d ? 32'h04 : 32'h20);
            @(negedge clk);
            ack = 1'b0;
            set_req(own_d, !own_d);
            #1;
            chk($sformatf("rr%0d_hgrant", k), 32'(grant), own_d ? 32'h2 : 32'h1);
            chk($sformatf("rr%0d_hcyc", k), 32'(cyc), 32'h0);
            @(negedge clk);
        end

        // ibus 8-beat wrap burst; dbus requests from beat 2 and must wait.
        do_reset();
        set_req(1'b1, 1'b0);
        icti = 3'b010; ibte = 2'b10;
        rdat = 32'h0BAD_F00D;
        #1 chk("bu_idle", 32'(grant), 32'h0);
        @(negedge clk);
        for (int b = 1; b <= 8; b++) begin
            if (b >= 2) set_req(1'b1, 1'b1);
            icti = (b == 8) ? 3'b111 : 3'b010;
            ack = 1'b1;
            #1;
            chk($sformatf("bu%0d_grant", b), 32'(grant), 32'h1);
            chk($sformatf("bu%0d_pgrant", b), 32'(p_grant), 32'h1);
            chk($sformatf("bu%0d_ctibte", b), 32'({cti, bte}), 32'({icti, 2'b10}));
            chk($sformatf("bu%0d_rsp", b), 32'(rsp), 32'h20);
            chk($sformatf("bu%0d_pctl", b),
                32'({p_cyc, p_stb, p_we, p_sel, p_cti, p_bte, p_rsp}),
                32'({3'b110, 4'hf, icti, 2'b10, 6'b100000}));
            chk($sformatf("bu%0d_padr", b), p_adr, A1);
            chk($sformatf("bu%0d_pdat", b), p_dat, IDAT);
            chk($sformatf("bu%0d_pidat", b), p_idat, 32'h0BAD_F00D);
            chk($sformatf("bu%0d_pddat", b), p_ddat, 32'h0BAD_F00D);
            @(negedge clk);
        end
        ack = 1'b0;
        set_req(1'b0, 1'b1);
        #1 chk("bu_rel_grant", 32'(grant), 32'h1);
        @(negedge clk);
        #1;
        chk("bu_d_grant", 32'(grant), 32'h2);
        chk("bu_d_pgrant", 32'(p_grant), 32'h2);
        chk("bu_d_adr", adr, D1);

        // Timeout: slave silent, abort after the 5th stb cycle.
        do_reset();
        set_req(1'b0, 1'b1);
        @(negedge clk);
        for (int s = 1; s <= 5; s++) begin
            #1;
            chk($sformatf("to%0d_grant", s), 32'(grant), 32'h2);
            chk($sformatf("to%0d_cyc", s), 32'(cyc), 32'h1);
            chk($sformatf("to%0d_derr", s), 32'(derr), 32'h0);
            @(negedge clk);
        end
        set_req(1'b0, 1'b0);
        ack = 1'b1;
        #1;
        chk("ab_grant", 32'(grant), 32'h2);
        chk("ab_cycstb", 32'({cyc, stb}), 32'h0);
        chk("ab_adr", adr, 32'h0);
        chk("ab_rsp", 32'(rsp), 32'h02);
        chk("ab_nodis_derr", 32'(p_derr), 32'h0);
        @(negedge clk);
        ack = 1'b0;
        #1 chk("ab_idle", 32'(grant), 32'h0);

        // Response on the cycle the counter hits TIMEOUT wins and restarts the count.
        do_reset();
        set_req(1'b0, 1'b1);
        @(negedge clk);
        repeat (4) @(negedge clk);
        ack = 1'b1;
        #1;
        chk("tw_rsp", 32'(rsp), 32'h04);
        chk("tw_grant", 32'(grant), 32'h2);
        @(negedge clk);
        ack = 1'b0;
        for (int s = 6; s <= 10; s++) begin
            #1;
            chk($sformatf("tw%0d_state", s), 32'({grant, cyc, derr}), 32'({2'b10, 1'b1, 1'b0}));
            @(negedge clk);
        end

        // Round-robin vs dbus priority on a tie after dbus was served.
        do_reset();
        set_req(1'b0, 1'b1);
        @(negedge clk);
        #1 chk("pr_d_grant", 32'(grant), 32'h2);
        @(negedge clk);
        set_req(1'b0, 1'b0);
        @(negedge clk);
        set_req(1'b1, 1'b1);
        #1 chk("pr_idle", 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        chk("pr_rr_grant", 32'(grant), 32'h1);
        chk("pr_dp_grant", 32'(p_grant), 32'h2);

        // Asynchronous reset in the middle of a dbus burst.
        do_reset();
        set_req(1'b0, 1'b1);
        dcti = 3'b010;
        @(negedge clk);
        for (int b = 1; b <= 3; b++) begin
            ack = 1'b1;
            #1;
            chk($sformatf("ar%0d_grant", b), 32'(grant), 32'h2);
            chk($sformatf("ar%0d_wsd", b), 32'({cyc, we, sel}), 32'({1'b1, 1'b1, 4'hc}));
            chk($sformatf("ar%0d_dat", b), dat, DDAT);
            if (b < 3) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cycstb", 32'({cyc, stb}), 32'h0);
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_rsp", 32'(rsp), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ack = 1'b0;
        dcti = 3'b000;
        set_req(1'b1, 1'b1);
        #1 chk("ar_rel_idle", 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        chk("ar_tie_rr", 32'(grant), 32'h2);
        chk("ar_tie_dp", 32'(p_grant), 32'h2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
